// File: rtl/instruction_assembler_if.sv
// Memory-side / decoder-side bus of the instruction assembler.
// The decoder side sees the assembled word, Valid, SliceCnt and Overrun.
interface instruction_assembler_if #(
  parameter int SLICE_W = 8,
  parameter int SLICES  = 2
);
  localparam int IDX_W = $clog2(SLICES);

  logic [SLICE_W-1:0]        I;
  logic                      Write;
  logic                      Mode;
  logic [IDX_W-1:0]          Sel;
  logic                      Clear;
  logic                      Ack;
  logic [SLICE_W*SLICES-1:0] IROut;
  logic                      Valid;
  logic [IDX_W:0]            SliceCnt;
  logic                      Overrun;

  modport slave  (input  I, Write, Mode, Sel, Clear, Ack,
                  output IROut, Valid, SliceCnt, Overrun);
  modport master (output I, Write, Mode, Sel, Clear, Ack,
                  input  IROut, Valid, SliceCnt, Overrun);
endinterface

// File: rtl/instruction_assembler.sv
// Assembles SLICES x SLICE_W instruction words from memory slices (auto or indexed).
// Optional sticky write-while-full flag: define INSTRUCTION_ASSEMBLER_OVERRUN_EN.
module instruction_assembler #(
    parameter int SLICE_W = 8,
    parameter int SLICES  = 2
) (
    input logic                    Clock,
    input logic                    ResetN,
    instruction_assembler_if.slave bus
);
    localparam int IDX_W = $clog2(SLICES);

    typedef enum logic [1:0] {EMPTY, FILLING, FULL} state_t;

    state_t                          state_q, state_d;
    logic [SLICES-1:0]               mask_q, mask_d, base_mask, load;
    logic [SLICES-1:0][SLICE_W-1:0]  data_q;
    logic [IDX_W-1:0]                tgt;
    logic                            tgt_ok, rel, accept;
    logic [IDX_W:0]                  cnt;

    // Release on Ack happens before the write so a same-cycle write lands in an empty word
    always_comb begin
        rel       = bus.Ack && (state_q == FULL);
        base_mask = rel ? '0 : mask_q;
        tgt       = '0;
        tgt_ok    = 1'b0;
        if (bus.Mode) begin
            for (int k = SLICES - 1; k >= 0; k--) begin
                if (!base_mask[k]) begin
                    tgt    = IDX_W'(k);
                    tgt_ok = 1'b1;
                end
            end
        end else begin
            tgt    = bus.Sel;
            tgt_ok = int'(bus.Sel) < SLICES;
        end
        accept = bus.Write && tgt_ok && !((state_q == FULL) && !bus.Ack);
        for (int k = 0; k < SLICES; k++)
            load[k] = accept && (tgt == IDX_W'(k));
        mask_d = bus.Clear ? '0 : (base_mask | load);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = (&mask_d) ? FULL : FILLING;
            FILLING: if (&mask_d) state_d = FULL;
            FULL:    if (rel) state_d = accept ? FILLING : EMPTY;
            default: state_d = EMPTY;
        endcase
        if (bus.Clear) state_d = EMPTY;
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= EMPTY;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
        end
    end

    for (genvar k = 0; k < SLICES; k++) begin : g_slice
        always_ff @(posedge Clock or negedge ResetN) begin
            if (!ResetN)        data_q[k] <= '0;
            else if (bus.Clear) data_q[k] <= '0;
            else if (load[k])   data_q[k] <= bus.I;
        end
    end

    always_comb begin
        cnt = '0;
        for (int k = 0; k < SLICES; k++)
            cnt = cnt + (IDX_W + 1)'(mask_q[k]);
    end

    assign bus.IROut    = data_q;
    assign bus.Valid    = (state_q == FULL);
    assign bus.SliceCnt = cnt;

`ifdef INSTRUCTION_ASSEMBLER_OVERRUN_EN
    logic overrun_q;
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN)        overrun_q <= 1'b0;
        else if (bus.Clear) overrun_q <= 1'b0;
        else if (bus.Write && (state_q == FULL) && !bus.Ack) overrun_q <= 1'b1;
    end
    assign bus.Overrun = overrun_q;
`else
    assign bus.Overrun = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_assembler.sv
// Directed bench for instruction_assembler: a 2-slice and a 3-slice instance.
module tb_instruction_assembler;
  logic Clock = 1'b0;
  logic ResetN = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic exp_ovr;

  always #5 Clock = ~Clock;

  instruction_assembler_if #(.SLICE_W(8), .SLICES(2)) ifc ();
  instruction_assembler_if #(.SLICE_W(8), .SLICES(3)) ifc3 ();

  instruction_assembler #(.SLICE_W(8), .SLICES(2)) dut (
    .Clock(Clock), .ResetN(ResetN), .bus(ifc.slave));
  instruction_assembler #(.SLICE_W(8), .SLICES(3)) dut3 (
    .Clock(Clock), .ResetN(ResetN), .bus(ifc3.slave));

  task automatic idle();
    ifc.I = '0; ifc.Write = 0; ifc.Mode = 0; ifc.Sel = '0; ifc.Clear = 0; ifc.Ack = 0;
    ifc3.I = '0; ifc3.Write = 0; ifc3.Mode = 0; ifc3.Sel = '0; ifc3.Clear = 0; ifc3.Ack = 0;
  endtask

  // One cycle on the 2-slice DUT; returns 1 time unit after the edge
  task automatic drive(input logic w, input logic m, input logic s, input logic [7:0] d,
                       input logic a, input logic c);
    ifc.Write = w; ifc.Mode = m; ifc.Sel = s; ifc.I = d; ifc.Ack = a; ifc.Clear = c;
    @(posedge Clock); #1;
    idle();
  endtask

  task automatic drive3(input logic w, input logic m, input logic [1:0] s, input logic [7:0] d);
    ifc3.Write = w; ifc3.Mode = m; ifc3.Sel = s; ifc3.I = d;
    @(posedge Clock); #1;
    idle();
  endtask

  task automatic test_reset();
    checks++; if (ifc.IROut !== 16'h0) begin errors++; $display("FAIL reset_irout got=%h exp=%h", ifc.IROut, 16'h0); end
    checks++; if (ifc.Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ifc.Valid); end
    checks++; if (ifc.SliceCnt !== 2'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", ifc.SliceCnt); end
    checks++; if (ifc.Overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", ifc.Overrun); end
  endtask

  task automatic test_auto();
    drive(1, 1, 0, 8'h34, 0, 0);
    checks++; if (ifc.SliceCnt !== 2'd1) begin errors++; $display("FAIL auto_cnt1 got=%0d exp=1", ifc.SliceCnt); end
    checks++; if (ifc.Valid !== 1'b0) begin errors++; $display("FAIL auto_valid1 got=%b exp=0", ifc.Valid); end
    drive(1, 1, 0, 8'h12, 0, 0);
    checks++; if (ifc.IROut !== 16'h1234) begin errors++; $display("FAIL auto_irout got=%h exp=1234", ifc.IROut); end
    checks++; if (ifc.Valid !== 1'b1) begin errors++; $display("FAIL auto_valid2 got=%b exp=1", ifc.Valid); end
    checks++; if (ifc.SliceCnt !== 2'd2) begin errors++; $display("FAIL auto_cnt2 got=%0d exp=2", ifc.SliceCnt); end
  endtask

  // Starts from FULL holding 0x1234
  task automatic test_overrun();
    drive(1, 1, 0, 8'h55, 0, 0);
    checks++; if (ifc.IROut !== 16'h1234) begin errors++; $display("FAIL ovr_irout got=%h exp=1234", ifc.IROut); end
    checks++; if (ifc.Valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got=%b exp=1", ifc.Valid); end
    checks++; if (ifc.Overrun !== exp_ovr) begin errors++; $display("FAIL ovr_flag got=%b exp=%b", ifc.Overrun, exp_ovr); end
    drive(0, 0, 0, 8'h00, 0, 1);
    checks++; if (ifc.IROut !== 16'h0) begin errors++; $display("FAIL ovr_clr_irout got=%h exp=0000", ifc.IROut); end
    checks++; if (ifc.Overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr_flag got=%b exp=0", ifc.Overrun); end
    checks++; if (ifc.SliceCnt !== 2'd0) begin errors++; $display("FAIL ovr_clr_cnt got=%0d exp=0", ifc.SliceCnt); end
    checks++; if (ifc.Valid !== 1'b0) begin errors++; $display("FAIL ovr_clr_valid got=%b exp=0", ifc.Valid); end
  endtask

  task automatic test_back_to_back();
    drive(1, 1, 0, 8'h34, 0, 0);
    drive(1, 1, 0, 8'h12, 0, 0);
    drive(1, 1, 0, 8'h77, 1, 0);
    checks++; if (ifc.Valid !== 1'b0) begin errors++; $display("FAIL b2b_valid got=%b exp=0", ifc.Valid); end
    checks++; if (ifc.SliceCnt !== 2'd1) begin errors++; $display("FAIL b2b_cnt got=%0d exp=1", ifc.SliceCnt); end
    checks++; if (ifc.IROut !== 16'h1277) begin errors++; $display("FAIL b2b_irout got=%h exp=1277", ifc.IROut); end
    drive(1, 1, 0, 8'h99, 0, 0);
    checks++; if (ifc.IROut !== 16'h9977) begin errors++; $display("FAIL b2b_irout2 got=%h exp=9977", ifc.IROut); end
    checks++; if (ifc.Valid !== 1'b1) begin errors++; $display("FAIL b2b_valid2 got=%b exp=1", ifc.Valid); end
  endtask

  task automatic test_indexed();
    drive(0, 0, 0, 8'h00, 0, 1);
    drive(1, 0, 1, 8'hAB, 0, 0);
    checks++; if (ifc.SliceCnt !== 2'd1) begin errors++; $display("FAIL idx_cnt1 got=%0d exp=1", ifc.SliceCnt); end
    checks++; if (ifc.IROut !== 16'hAB00) begin errors++; $display("FAIL idx_irout1 got=%h exp=ab00", ifc.IROut); end
    drive(1, 0, 1, 8'hEF, 0, 0);
    checks++; if (ifc.SliceCnt !== 2'd1) begin errors++; $display("FAIL idx_cnt2 got=%0d exp=1", ifc.SliceCnt); end
    checks++; if (ifc.Valid !== 1'b0) begin errors++; $display("FAIL idx_valid2 got=%b exp=0", ifc.Valid); end
    checks++; if (ifc.IROut !== 16'hEF00) begin errors++; $display("FAIL idx_irout2 got=%h exp=ef00", ifc.IROut); end
    drive(1, 0, 0, 8'hCD, 0, 0);
    checks++; if (ifc.IROut !== 16'hEFCD) begin errors++; $display("FAIL idx_irout3 got=%h exp=efcd", ifc.IROut); end
    checks++; if (ifc.Valid !== 1'b1) begin errors++; $display("FAIL idx_valid3 got=%b exp=1", ifc.Valid); end
  endtask

  task automatic test_indexed3();
    drive3(1, 0, 2'd2, 8'h5A);
    checks++; if (ifc3.IROut !== 24'h5A0000) begin errors++; $display("FAIL idx3_sel2 got=%h exp=5a0000", ifc3.IROut); end
    checks++; if (ifc3.SliceCnt !== 3'd1) begin errors++; $display("FAIL idx3_cnt1 got=%0d exp=1", ifc3.SliceCnt); end
    drive3(1, 0, 2'd3, 8'hEE);
    checks++; if (ifc3.IROut !== 24'h5A0000) begin errors++; $display("FAIL idx3_sel3_irout got=%h exp=5a0000", ifc3.IROut); end
    checks++; if (ifc3.SliceCnt !== 3'd1) begin errors++; $display("FAIL idx3_sel3_cnt got=%0d exp=1", ifc3.SliceCnt); end
    drive3(1, 1, 2'd0, 8'h11);
    drive3(1, 1, 2'd0, 8'h22);
    checks++; if (ifc3.IROut !== 24'h5A2211) begin errors++; $display("FAIL idx3_mixed got=%h exp=5a2211", ifc3.IROut); end
    checks++; if (ifc3.Valid !== 1'b1) begin errors++; $display("FAIL idx3_valid got=%b exp=1", ifc3.Valid); end
  endtask

  task automatic test_clear_priority();
    drive(0, 0, 0, 8'h00, 0, 1);
    drive(1, 1, 0, 8'h34, 0, 0);
    drive(1, 1, 0, 8'h12, 0, 0);
    drive(1, 1, 0, 8'h66, 1, 1);
    checks++; if (ifc.IROut !== 16'h0) begin errors++; $display("FAIL clr_irout got=%h exp=0000", ifc.IROut); end
    checks++; if (ifc.Valid !== 1'b0) begin errors++; $display("FAIL clr_valid got=%b exp=0", ifc.Valid); end
    checks++; if (ifc.SliceCnt !== 2'd0) begin errors++; $display("FAIL clr_cnt got=%0d exp=0", ifc.SliceCnt); end
    drive(1, 1, 0, 8'h42, 0, 0);
    drive(0, 0, 0, 8'h00, 1, 0);
    checks++; if (ifc.SliceCnt !== 2'd1) begin errors++; $display("FAIL stray_ack_cnt got=%0d exp=1", ifc.SliceCnt); end
    checks++; if (ifc.IROut !== 16'h0042) begin errors++; $display("FAIL stray_ack_irout got=%h exp=0042", ifc.IROut); end
    checks++; if (ifc.Valid !== 1'b0) begin errors++; $display("FAIL stray_ack_valid got=%b exp=0", ifc.Valid); end
  endtask

  // Mid-fill with 0x42 in slice 0; reset lands between edges
  task automatic test_async_reset();
    drive(1, 0, 1, 8'h31, 0, 0);
    checks++; if (ifc.Valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid got=%b exp=1", ifc.Valid); end
    drive(1, 1, 0, 8'h55, 0, 0);
    drive(0, 0, 0, 8'h00, 1, 0);
    drive(1, 1, 0, 8'h34, 0, 0);
    #2 ResetN = 1'b0;
    #1;
    checks++; if (ifc.IROut !== 16'h0) begin errors++; $display("FAIL ar_irout got=%h exp=0000", ifc.IROut); end
    checks++; if (ifc.SliceCnt !== 2'd0) begin errors++; $display("FAIL ar_cnt got=%0d exp=0", ifc.SliceCnt); end
    checks++; if (ifc.Overrun !== 1'b0) begin errors++; $display("FAIL ar_overrun got=%b exp=0", ifc.Overrun); end
    checks++; if (ifc3.IROut !== 24'h0) begin errors++; $display("FAIL ar_irout3 got=%h exp=000000", ifc3.IROut); end
    #3 ResetN = 1'b1;
    drive(1, 1, 0, 8'h56, 0, 0);
    checks++; if (ifc.IROut !== 16'h0056) begin errors++; $display("FAIL ar_after_irout got=%h exp=0056", ifc.IROut); end
    checks++; if (ifc.SliceCnt !== 2'd1) begin errors++; $display("FAIL ar_after_cnt got=%0d exp=1", ifc.SliceCnt); end
  endtask

  initial begin
`ifdef INSTRUCTION_ASSEMBLER_OVERRUN_EN
    exp_ovr = 1'b1;
`else
    exp_ovr = 1'b0;
`endif
    idle();
    #1;
    test_reset();
    #11 ResetN = 1'b1;
    test_auto();
    test_overrun();
    test_back_to_back();
    test_indexed();
    test_indexed3();
    test_clear_priority();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instruction_assembler.md
# instruction_assembler

Parametrised instruction register that assembles a `SLICES × SLICE_W`-bit instruction word from sequential memory slices. It tracks which slices are filled and presents a registered `Valid` to the control unit / decoder. The decoder releases the word with `Ack`. It sits between the memory data bus and the decoder, and supports auto-sequenced or explicitly indexed slice loads.

## Interface
- `SLICE_W`, 8, width of one memory slice (≥1)
- `SLICES`, 2, slices per instruction word (≥2)
- `IDX_W`, `$clog2(SLICES)`, slice index width (derived, not overridden)
- `Clock`  in  1  rising-edge clock; the only clock
- `ResetN`  in  1  asynchronous, active-low reset
- `I`  in  SLICE_W  slice data from memory
- `Write`  in  1  load request for one slice this cycle
- `Mode`  in  1  0 = indexed (slice chosen by `Sel`); 1 = auto (lowest unfilled slice)
- `Sel`  in  IDX_W  target slice in indexed mode; ignored in auto mode
- `Clear`  in  1  synchronous discard of the partial or complete word
- `Ack`  in  1  decoder has consumed the word
- `IROut`  out  SLICE_W*SLICES  assembled word; slice k occupies bits `[k*SLICE_W +: SLICE_W]`
- `Valid`  out  1  word complete (state FULL)
- `SliceCnt`  out  IDX_W+1  number of filled slices
- `Overrun`  out  1  sticky write-while-full flag (see Configuration)

## Operation
- State: `mask[SLICES-1:0]` holds per-slice filled bits. FSM states are EMPTY (mask = 0), FILLING (mask partial) and FULL (mask all ones).
- Write target:
  - Indexed mode: the target is `Sel`. If `Sel ≥ SLICES`, the write is ignored with no state change.
  - Auto mode: the target is the lowest-index slice whose mask bit is 0 (priority encoder).
- An accepted write loads `I` into the target slice and sets its mask bit.
- An indexed write to an already-filled slice overwrites the data. The mask is unchanged.
- Transitions:
  - EMPTY → FILLING on the first accepted write.
  - FILLING → FULL when the write sets the last mask bit.
  - FULL → EMPTY on `Ack`.
- FULL:
  - A write without `Ack` is ignored; it sets `Overrun` when enabled. `IROut` holds.
  - With `Ack` and `Write` in the same cycle, the release happens first. The write then lands in an empty word (auto → slice 0, indexed → `Sel`). Next state is FILLING with mask = one bit.
- `Ack` is ignored unless `Valid` = 1.
- `Clear` has priority over `Write` and `Ack`. It sets mask = 0 and state EMPTY, and zeroes `IROut`.
- Release on `Ack` clears only the mask. `IROut` retains the old data until it is overwritten.
- `Mode` is sampled on each write. Mixing modes within one word is legal and follows the target rules above.
- `SliceCnt` = popcount(mask). `Valid` = (state == FULL).

## Timing
- All state updates happen on the rising edge of `Clock`. Outputs are registered or decoded from registers only; there is no combinational path from inputs to outputs.
- Latency: a write on edge n is visible on `IROut`, `SliceCnt` and `Valid` after edge n. `Valid` rises in the cycle following the final slice's edge.
- Minimum word turnaround is SLICES cycles. Back-to-back words need no bubble when `Ack` coincides with the first write of the next word.
- Reset (`ResetN` = 0, asynchronous, at any time including mid-fill): `IROut` = 0, mask = 0, state EMPTY, `Valid` = 0, `SliceCnt` = 0, `Overrun` = 0. The first edge after deassertion behaves as from EMPTY.

## Configuration
- Macro: `INSTRUCTION_ASSEMBLER_OVERRUN_EN`.
- Defined: `Overrun` is a sticky register. It is set on a `Write` in FULL without `Ack`, and cleared only by `Clear` or reset.
- Undefined: the `Overrun` port remains but is tied to 0, and no register is built. All other behaviour is identical.

## Test plan
- Auto, SLICES=2, SLICE_W=8: write 0x34 then 0x12 → after edge 1 `SliceCnt`=1, `Valid`=0; after edge 2 `IROut`=0x1234, `Valid`=1, `SliceCnt`=2.
- Indexed: Sel=1/0xAB, Sel=1/0xEF (overwrite), Sel=0/0xCD → `IROut`=0xEFCD and `Valid`=1 only after the third write; Sel=2 with SLICES=3 loads bits [23:16].
- FULL at 0x1234, then Write 0x55 with no Ack → `IROut` stays 0x1234 and `Overrun`=1 (macro defined) or 0 (undefined); then Clear → `IROut`=0, `Overrun`=0, EMPTY.
- FULL at 0x1234, then Ack + Write 0x77 (auto) in the same cycle → `Valid`=0, `SliceCnt`=1, `IROut`[7:0]=0x77, `IROut`[15:8]=0x12.
- Mid-fill (one slice loaded), assert `ResetN`=0 between edges → all outputs 0 immediately, without waiting for a clock edge; the next auto write lands in slice 0.
- Clear + Write same cycle, and Ack while `Valid`=0 → Clear wins (EMPTY, `IROut`=0); the stray Ack produces no change.
